// File: rtl/mem_access_ctrl.sv
// Single-outstanding memory access controller: takes one load/store from the issue
// buffer, drives it to memory, waits for ack/return data and reports completion.
module mem_access_ctrl #(
    parameter int register_width = 32,
    parameter int des            = 4,
    parameter int branch_id      = 3,
    parameter int max_wait       = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    // Buffer side. A request is taken on a rising edge where req_vld=1 and
    // req_rdy=1 (IDLE only); req_vld need not be held once dropped.
    input  logic                      req_vld,
    input  logic                      req_load,
    input  logic                      req_store,
    input  logic [register_width-1:0] req_addr,
    input  logic [register_width-1:0] req_data,
    input  logic [des-1:0]            req_des,
    input  logic [branch_id-1:0]      req_branch,
    output logic                      req_rdy,
    input  logic                      flush_en,
    input  logic [branch_id-1:0]      flush_id,
    // Memory side: mem_req and its payload stay stable until mem_ack=1.
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [register_width-1:0] mem_addr,
    output logic [register_width-1:0] mem_wdata,
    input  logic                      mem_ack,
    input  logic                      mem_rvld,
    input  logic [register_width-1:0] mem_rdata,
    output logic                      mem_in_done,
    output logic                      load_wr_en,
    output logic [register_width-1:0] load_data,
    output logic [des-1:0]            load_des,
    output logic                      timeout_err,
    output logic [1:0]                dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(max_wait);

    state_t                    state_q, state_d;
    logic [register_width-1:0] addr_q, addr_d;
    logic [register_width-1:0] wdata_q, wdata_d;
    logic [register_width-1:0] load_data_q, load_data_d;
    logic [des-1:0]            des_q, des_d;
    logic [branch_id-1:0]      branch_q, branch_d;
    logic                      is_load_q, is_load_d;
    logic                      kill_q, kill_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      timeout_q, timeout_d;

    logic type_ok;
    logic req_flushed;
    logic kill_now;

    assign type_ok     = req_load ^ req_store;
    assign req_flushed = flush_en && (flush_id == req_branch);
    // A flush hitting this cycle counts immediately, not only once registered.
    assign kill_now    = kill_q || (flush_en && (flush_id == branch_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            des_q       <= '0;
            branch_q    <= '0;
            is_load_q   <= 1'b0;
            kill_q      <= 1'b0;
            cnt_q       <= 4'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            des_q       <= des_d;
            branch_q    <= branch_d;
            is_load_q   <= is_load_d;
            kill_q      <= kill_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        des_d       = des_q;
        branch_d    = branch_q;
        is_load_d   = is_load_q;
        kill_d      = kill_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                if (req_vld && type_ok && !req_flushed) begin
                    addr_d    = req_addr;
                    wdata_d   = req_data;
                    des_d     = req_des;
                    branch_d  = req_branch;
                    is_load_d = req_load;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                kill_d = kill_now;
                cnt_d  = cnt_q + 4'd1;
                // An ack beats both a same-cycle flush and a same-cycle timeout.
                if (mem_ack) begin
                    cnt_d = 4'd0;
                    if (is_load_q) begin
                        state_d = WAIT;
                    end else begin
                        state_d = kill_now ? IDLE : DONE;
                    end
                end else if (kill_now) begin
                    state_d = IDLE;
                end else if (cnt_q == MAX_CNT) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT: begin
                kill_d = kill_now;
                cnt_d  = cnt_q + 4'd1;
                // A killed load still drains its return but delivers nothing.
                if (mem_rvld) begin
                    if (kill_now) begin
                        state_d = IDLE;
                    end else begin
                        load_data_d = mem_rdata;
                        state_d     = DONE;
                    end
                end else if (cnt_q == MAX_CNT) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            kill_d = 1'b0;
            cnt_d  = 4'd0;
        end
    end

    assign req_rdy     = (state_q == IDLE);
    assign mem_req     = (state_q == ISSUE);
    assign mem_we      = (state_q == ISSUE) && !is_load_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_in_done = (state_q == DONE);
    assign load_wr_en  = (state_q == DONE) && is_load_q;
    assign load_data   = load_data_q;
    assign load_des    = des_q;
    assign timeout_err = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter register_width, default 'd32, data/address width.
REQ-002 SHALL have parameter des, default 'd4, destination tag width.
REQ-003 SHALL have parameter branch_id, default 'd3, branch tag width.
REQ-004 SHALL have parameter max_wait, default 'd15, timeout limit in cycles; the wait counter is 4 bits.
REQ-005 SHALL have one clock and asynchronous active-high reset: clk in 1, rising-edge clock; rst in 1, async active-high reset.
REQ-006 SHALL have these buffer-side ports:
- req_vld in 1: buffer presents a memory op.
- req_load in 1 and req_store in 1: op type.
- req_addr in register_width and req_data in register_width.
- req_des in des and req_branch in branch_id: op tags.
- req_rdy out 1: controller can accept.
REQ-007 SHALL have flush ports: flush_en in 1 and flush_id in branch_id.
REQ-008 SHALL have these memory-side ports:
- mem_req out 1, mem_we out 1, mem_addr out register_width, mem_wdata out register_width.
- mem_ack in 1: request accepted.
- mem_rvld in 1 and mem_rdata in register_width: load return.
REQ-009 SHALL have these result ports:
- mem_in_done out 1 and load_wr_en out 1.
- load_data out register_width and load_des out des.
- timeout_err out 1.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE, with all outputs decoded from registered state and registers.
REQ-011 SHALL drive req_rdy=1 only in IDLE.
REQ-012 SHALL accept a request in IDLE when all of these hold, capturing addr, data, des, branch and type, then moving to ISSUE next cycle:
- req_vld=1.
- Exactly one of req_load/req_store is 1.
- Not (flush_en=1 and flush_id==req_branch).
REQ-013 SHALL ignore a request with both or neither type bit set: no capture, stay IDLE.
REQ-014 SHALL hold mem_req=1 in ISSUE with mem_addr/mem_wdata/mem_we (mem_we=1 for store) stable until mem_ack.
REQ-015 SHALL leave ISSUE on mem_ack: store goes to DONE, load goes to WAIT.
REQ-016 SHALL, in WAIT, go to DONE on mem_rvld, capturing mem_rdata into load_data.
REQ-017 SHALL, in DONE (exactly one cycle), pulse mem_in_done=1 and, for a load, pulse load_wr_en=1 with load_des=captured des, then return to IDLE.
REQ-018 SHALL, in DONE, accept no new request; req_rdy=0.
REQ-019 SHALL meet these minimum latencies, with cycle 0 being the accept cycle:
- Store with ack in first ISSUE cycle: mem_in_done in cycle 2.
- Load: mem_in_done in the cycle after mem_rvld.
REQ-020 SHALL set a kill bit when flush_en=1 and flush_id==captured branch while in ISSUE or WAIT.
REQ-021 SHALL handle a kill in ISSUE with mem_ack=0 that cycle by dropping mem_req next cycle, returning to IDLE, and pulsing no done.
REQ-022 SHALL let mem_ack win over a flush when both occur in the same cycle: proceed as REQ-015 with the kill bit set.
REQ-023 SHALL, with the kill bit set, still drain WAIT until mem_rvld, then return to IDLE with no mem_in_done and no load_wr_en.
REQ-024 SHALL, for a killed store that is already acked, skip DONE and return to IDLE.
REQ-025 SHALL clear the wait counter on entry to ISSUE and WAIT and increment it each cycle in those states.
REQ-026 SHALL, when the counter equals max_wait and the awaited ack/rvld is absent that cycle, set timeout_err=1 (sticky until rst) and go to IDLE with no done; an ack/rvld in that cycle wins.
REQ-027 SHALL clear the kill bit on every return to IDLE.

Reset
REQ-028 SHALL, on rst=1 asynchronously, set state=IDLE, the following outputs to 0 (req_rdy=1 after reset), and clear the kill bit and counter:
- mem_req, mem_we, mem_in_done, load_wr_en, timeout_err.
- mem_addr, mem_wdata, load_data, load_des.
REQ-029 SHALL abandon any in-flight op on rst asserted mid-operation, with no done pulse after reset release.

Verification
REQ-030 SHALL cover these directed scenarios:
- Store addr=32'h40 data=32'hDEAD, mem_ack in first ISSUE cycle -> mem_req=1, mem_we=1 in cycle 1; mem_in_done=1 in cycle 2; load_wr_en=0.
- Load addr=32'h80 des=4'd7, ack at cycle 3, mem_rvld with 32'h1234 at cycle 5 -> cycle 6: mem_in_done=1, load_wr_en=1, load_des=7, load_data=32'h1234.
- Load branch=3 in WAIT, flush_en=1 flush_id=3, then rvld -> no mem_in_done, no load_wr_en; req_rdy=1 the cycle after rvld.
- req_vld with req_load=req_store=1 -> req_rdy stays 1, mem_req never asserts.
- Load, memory silent for 15 cycles -> timeout_err=1, return to IDLE; stays 1 until rst.
- rst pulsed while in WAIT -> all outputs 0 and req_rdy=1; a later mem_rvld causes no done.
